// File: rtl/uart_rx_ready.sv
// rtl/uart_rx_ready.sv - 8N1 UART receiver with mid-bit sampling and a valid/ready byte output.
// Optional even-parity frame (8E1) is enabled by defining UART_RX_PARITY_EN.
module uart_rx_ready #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, START, DATA, STOP
    } state_t;
`endif

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          deliver, deliver_n;
    logic          frame_err_n;
    logic          par_bit, par_bit_n;
    logic          perr;
    logic          handshake;
    logic          bit_end;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            deliver   <= 1'b0;
            frame_err <= 1'b0;
            par_bit   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            deliver   <= deliver_n;
            frame_err <= frame_err_n;
            par_bit   <= par_bit_n;
        end
    end

    assign bit_end = (cnt == BIT_END);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        deliver_n   = 1'b0;
        frame_err_n = 1'b0;
        par_bit_n   = par_bit;
        case (state)
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_END) begin
                    cnt_n   = '0;
                    // A line that is high again at mid start bit was only a glitch.
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    bit_idx_n        = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_n     = '0;
                    par_bit_n = rx_s;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        deliver_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        // Low stop bit: wait for a high line so a held break is not re-framed.
                        frame_err_n = 1'b1;
                        state_n     = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign perr = ^{shift, par_bit};
`else
    assign perr = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign handshake = data_valid & data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            if (deliver) begin
                // A byte leaving in this same cycle frees the slot for the new one.
                if (!data_valid || handshake) begin
                    data       <= shift;
                    data_valid <= 1'b1;
                    parity_err <= perr;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (handshake) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ready.sv
// tb/tb_uart_rx_ready.sv - scoreboard bench for uart_rx_ready with a byte-level reference model.
module tb_uart_rx_ready;

    localparam int CF  = 50_000_000;
    localparam int BR  = 2_900_000;
    localparam int CPB = CF / BR;

    logic       clk, rst, rx, data_ready;
    logic [7:0] data;
    logic       data_valid, busy, frame_err, overrun, parity_err;

    uart_rx_ready #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .busy(busy), .frame_err(frame_err),
        .overrun(overrun), .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];
    int cnt_fe = 0, cnt_ov = 0, cnt_pe = 0;
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;
    bit model_pending = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a good frame yields a byte unless the single output slot is full.
    task automatic expect_byte(input logic [7:0] b, input bit bad_parity);
        if (data_ready || !model_pending) begin
            sb.push_back(b);
            if (!data_ready) model_pending = 1;
            if (bad_parity) exp_pe++;
        end else begin
            exp_ov++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPB);
`endif
        rx = stop_bit;
        tick(CPB);
    endtask

    task automatic good_frame(input logic [7:0] b, input int gap);
        expect_byte(b, 1'b0);
        send_frame(b, 1'b1, 1'b0);
        rx = 1'b1;
        tick(gap);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {31'b0, data_valid}, 32'd1);
                chk("hold_data", {24'b0, data}, {24'b0, prev_data});
            end
            if (data_valid && data_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none at %0t", data, $time);
                end else begin
                    chk("data", {24'b0, data}, {24'b0, sb.pop_front()});
                end
            end
            cnt_fe += int'(frame_err);
            cnt_ov += int'(overrun);
            cnt_pe += int'(parity_err);
            prev_hold <= data_valid & ~data_ready;
            prev_data <= data;
        end
    end

    initial begin
        logic [7:0] b;
        rx = 1'b1;
        data_ready = 1'b1;
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        chk("reset_data", {24'b0, data}, 32'h0);
        chk("reset_valid", {31'b0, data_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd1);
        chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
        chk("reset_overrun", {31'b0, overrun}, 32'd0);
        chk("reset_parity_err", {31'b0, parity_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(5);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        good_frame(8'h54, CPB);
        good_frame(8'h2c, 2 * CPB);
        chk("cmd_bytes_drained", sb.size(), 32'd0);
        chk("cmd_frame_err", cnt_fe, exp_fe);
        chk("cmd_overrun", cnt_ov, exp_ov);

        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2 * CPB);
        chk("glitch_busy", {31'b0, busy}, 32'd0);
        chk("glitch_valid", {31'b0, data_valid}, 32'd0);
        chk("glitch_flags", cnt_fe + cnt_ov, 32'd0);
        good_frame(8'hA5, 2 * CPB);

        send_frame(8'h3C, 1'b0, 1'b0);
        exp_fe++;
        tick(3 * CPB);
        chk("break_busy", {31'b0, busy}, 32'd1);
        chk("break_frame_err", cnt_fe, exp_fe);
        chk("break_valid", {31'b0, data_valid}, 32'd0);
        rx = 1'b1;
        tick(6);
        chk("break_release_busy", {31'b0, busy}, 32'd0);
        good_frame(8'h11, 2 * CPB);

        data_ready = 1'b0;
        good_frame(8'h01, CPB);
        good_frame(8'h02, CPB);
        chk("ovr_count", cnt_ov, exp_ov);
        chk("ovr_valid", {31'b0, data_valid}, 32'd1);
        chk("ovr_data", {24'b0, data}, 32'h01);
        data_ready = 1'b1;
        model_pending = 0;
        tick(2);
        chk("ovr_release_valid", {31'b0, data_valid}, 32'd0);

        rx = 1'b0;
        tick(CPB);
        tick(4 * CPB);
        rx = 1'b1;
        tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(6 * CPB);
        chk("midrst_valid", {31'b0, data_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        good_frame(8'h7E, 2 * CPB);

`ifdef UART_RX_PARITY_EN
        expect_byte(8'h54, 1'b1);
        send_frame(8'h54, 1'b1, 1'b1);
        rx = 1'b1;
        tick(2 * CPB);
        chk("parity_bad_count", cnt_pe, exp_pe);
        good_frame(8'h54, 2 * CPB);
        chk("parity_good_count", cnt_pe, exp_pe);
`endif

        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            good_frame(b, $urandom_range(1, 2 * CPB));
        end

        tick(2 * CPB);
        chk("final_drained", sb.size(), 32'd0);
        chk("final_frame_err", cnt_fe, exp_fe);
        chk("final_overrun", cnt_ov, exp_ov);
        chk("final_parity_err", cnt_pe, exp_pe);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
